issue_select_multi: RTL and testbench

// Parametrised successor of the two-way issue picker in the out-of-order issue stage. Each cycle it

---
 rtl/issue_select_multi_pkg.sv | 38 +++
 rtl/issue_select_multi_rank.sv | 54 +++++
 rtl/issue_select_multi.sv | 151 +++++++++++++++
 tb/tb_issue_select_multi.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/issue_select_multi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : issue_select_multi_pkg
// Description : Shared types and sizing for the multi-channel issue picker:
//               reservation-buffer entry layout, entry state and unit enums.
// Revision    : 1.0 - initial release
// ============================================================================
package issue_select_multi_pkg;

    localparam int BUF_SIZE     = 8;
    localparam int BUF_SIZE_LOG = $clog2(BUF_SIZE);
    localparam int TAG_W        = BUF_SIZE_LOG + 1;

    typedef enum logic [1:0] {
        S_NOT_EXECUTED   = 2'd0,
        S_ADDR_GENERATED = 2'd1,
        S_EXECUTING      = 2'd2,
        S_DONE           = 2'd3
    } e_state_t;

    typedef enum logic [1:0] {
        ALU    = 2'd0,
        LOAD   = 2'd1,
        STORE  = 2'd2,
        BRANCH = 2'd3
    } unit_t;

    // Tag 0 marks an empty slot; Qj/Qk are producer tags, 0 = operand ready.
    typedef struct packed {
        logic [TAG_W-1:0] tag;
        e_state_t         e_state;
        logic [TAG_W-1:0] Qj;
        logic [TAG_W-1:0] Qk;
        unit_t            Unit;
    } entry_t;

endpackage
`default_nettype wire

// File: rtl/issue_select_multi_rank.sv
`default_nettype none
// ============================================================================
// Module      : issue_rank_topk
// Description : Combinational ordered top-K selector. Returns up to K eligible
//               buffer indices, oldest (largest tag) first; ties go to the
//               lower index.
// Revision    : 1.0 - initial release
// ============================================================================
module issue_rank_topk
    import issue_select_multi_pkg::*;
#(
    parameter int K = 2
) (
    input  logic [BUF_SIZE-1:0]                   elig,
    input  logic [BUF_SIZE-1:0][TAG_W-1:0]        tags,
    output logic [K-1:0]                          pick_valid,
    output logic [K-1:0][BUF_SIZE_LOG-1:0]        pick_idx
);

    logic [BUF_SIZE-1:0]     w_remain;
    logic                    w_found;
    logic [TAG_W-1:0]        w_best_tag;
    logic [BUF_SIZE_LOG-1:0] w_best_idx;

    // K successive max-tag scans, each removing its winner from the candidate set
    always_comb begin
        w_remain   = elig;
        pick_valid = '0;
        pick_idx   = '0;
        w_found    = 1'b0;
        w_best_tag = '0;
        w_best_idx = '0;
        for (int p = 0; p < K; p++) begin
            w_found    = 1'b0;
            w_best_tag = '0;
            w_best_idx = '0;
            for (int i = 0; i < BUF_SIZE; i++) begin
                // strict compare keeps the lowest index on a tie
                if (w_remain[i] && (!w_found || (tags[i] > w_best_tag))) begin
                    w_found    = 1'b1;
                    w_best_tag = tags[i];
                    w_best_idx = BUF_SIZE_LOG'(i);
                end
            end
            pick_valid[p] = w_found;
            pick_idx[p]   = w_best_idx;
            if (w_found) begin
                w_remain[w_best_idx] = 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/issue_select_multi.sv
`default_nettype none
// ============================================================================
// Module      : issue_select_multi
// Description : Multi-channel issue picker. Selects up to ISSUE_WIDTH eligible
//               reservation-buffer entries in tag order into per-channel
//               registers that hold until the functional unit accepts.
// Revision    : 1.0 - initial release
// ============================================================================
module issue_select_multi
    import issue_select_multi_pkg::*;
#(
    parameter int ISSUE_WIDTH = 2
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  entry_t                                 entries [BUF_SIZE],
    input  logic                                   flush,
    input  logic [ISSUE_WIDTH-1:0]                 fu_ready,
    output logic [ISSUE_WIDTH-1:0]                 issue_valid,
    output logic [ISSUE_WIDTH-1:0][BUF_SIZE_LOG-1:0] issue_idx,
    output logic [ISSUE_WIDTH-1:0][TAG_W-1:0]      issue_tag,
    output logic [BUF_SIZE-1:0]                    issue_fire
);

    logic [ISSUE_WIDTH-1:0]                   valid_q, valid_d;
    logic [ISSUE_WIDTH-1:0][BUF_SIZE_LOG-1:0] idx_q, idx_d;
    logic [ISSUE_WIDTH-1:0][TAG_W-1:0]        tag_q, tag_d;

    logic [ISSUE_WIDTH-1:0]                   w_fire;
    logic [ISSUE_WIDTH-1:0]                   w_free;
    logic [BUF_SIZE-1:0]                      w_pending;
    logic [BUF_SIZE-1:0]                      w_elig;
    logic [BUF_SIZE-1:0][TAG_W-1:0]           w_tags;
    logic [BUF_SIZE-1:0]                      w_older_store;
    logic                                     w_dup_tag;
    logic [ISSUE_WIDTH-1:0]                   w_pick_valid;
    logic [ISSUE_WIDTH-1:0][BUF_SIZE_LOG-1:0] w_pick_idx;

    // Handshake decode: per-channel fire, entry fire map and held-entry mask.
    // A channel firing this cycle still counts as pending, because the buffer
    // only advances the entry state at the coming edge.
    always_comb begin
        w_fire     = '0;
        w_pending  = '0;
        issue_fire = '0;
        for (int k = 0; k < ISSUE_WIDTH; k++) begin
            w_fire[k] = valid_q[k] & fu_ready[k] & ~rst;
            if (valid_q[k]) begin
                w_pending[idx_q[k]] = 1'b1;
            end
            if (w_fire[k]) begin
                issue_fire[idx_q[k]] = 1'b1;
            end
        end
        w_free = ~valid_q | w_fire;
    end

    // Per-entry eligibility: operands ready, or address generated with no older store
    always_comb begin
        w_tags        = '0;
        w_older_store = '0;
        w_elig        = '0;
        for (int i = 0; i < BUF_SIZE; i++) begin
            w_tags[i] = entries[i].tag;
            for (int j = 0; j < BUF_SIZE; j++) begin
                if ((entries[j].Unit == STORE) && (entries[j].tag != '0) &&
                    (entries[j].tag > entries[i].tag)) begin
                    w_older_store[i] = 1'b1;
                end
            end
            w_elig[i] = (entries[i].tag != '0) && !w_pending[i] &&
                        (((entries[i].e_state == S_NOT_EXECUTED) &&
                          (entries[i].Qj == '0) && (entries[i].Qk == '0)) ||
                         ((entries[i].e_state == S_ADDR_GENERATED) && !w_older_store[i]));
        end
    end

    issue_rank_topk #(
        .K (ISSUE_WIDTH)
    ) u_rank (
        .elig       (w_elig),
        .tags       (w_tags),
        .pick_valid (w_pick_valid),
        .pick_idx   (w_pick_idx)
    );

    // Fill/hold mux: the n-th free channel (ascending k) takes the n-th ranked pick
    always_comb begin
        int slot;
        valid_d = valid_q;
        idx_d   = idx_q;
        tag_d   = tag_q;
        slot    = 0;
        for (int k = 0; k < ISSUE_WIDTH; k++) begin
            if (w_free[k]) begin
                valid_d[k] = 1'b0;
                for (int p = 0; p < ISSUE_WIDTH; p++) begin
                    if ((p == slot) && w_pick_valid[p]) begin
                        valid_d[k] = 1'b1;
                        idx_d[k]   = w_pick_idx[p];
                        tag_d[k]   = w_tags[w_pick_idx[p]];
                    end
                end
                slot = slot + 1;
            end
        end
        if (flush) begin
            valid_d = '0;
        end
    end

    // Channel registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            idx_q   <= '0;
            tag_q   <= '0;
        end else begin
            valid_q <= valid_d;
            idx_q   <= idx_d;
            tag_q   <= tag_d;
        end
    end

    assign issue_valid = valid_q;
    assign issue_idx   = idx_q;
    assign issue_tag   = tag_q;

    // Duplicate non-zero tag detection for the buffer-integrity assertion
    always_comb begin
        w_dup_tag = 1'b0;
        for (int i = 0; i < BUF_SIZE; i++) begin
            for (int j = i + 1; j < BUF_SIZE; j++) begin
                if ((entries[i].tag != '0) && (entries[i].tag == entries[j].tag)) begin
                    w_dup_tag = 1'b1;
                end
            end
        end
    end

`ifndef SYNTHESIS
    // The reservation buffer must never present two live entries with one tag
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!w_dup_tag);
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_issue_select_multi.sv
`default_nettype none
// ============================================================================
// Module      : tb_issue_select_multi
// Description : Self-checking bench for issue_select_multi with directed
//               scenarios and randomized buffer traffic against a tag-ordered
//               reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_issue_select_multi;
    import issue_select_multi_pkg::*;

    localparam int IW = 2;

    logic                          clk = 1'b0;
    logic                          rst;
    entry_t                        ent [BUF_SIZE];
    logic                          flush;
    logic [IW-1:0]                 fu_ready;
    logic [IW-1:0]                 issue_valid;
    logic [IW-1:0][BUF_SIZE_LOG-1:0] issue_idx;
    logic [IW-1:0][TAG_W-1:0]      issue_tag;
    logic [BUF_SIZE-1:0]           issue_fire;

    // reference channel state
    bit   m_valid [IW];
    int   m_idx   [IW];
    int   m_tag   [IW];
    logic [BUF_SIZE-1:0] seen_fire;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    issue_select_multi #(
        .ISSUE_WIDTH (IW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .entries     (ent),
        .flush       (flush),
        .fu_ready    (fu_ready),
        .issue_valid (issue_valid),
        .issue_idx   (issue_idx),
        .issue_tag   (issue_tag),
        .issue_fire  (issue_fire)
    );

    task automatic check_eq(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, obs, exp, $time);
        end
    endtask

    function automatic bit held(int i);
        for (int k = 0; k < IW; k++)
            if (m_valid[k] && m_idx[k] == i) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit eligible(int i);
        if (ent[i].tag == 0 || held(i)) return 1'b0;
        if (ent[i].e_state == S_NOT_EXECUTED)
            return (ent[i].Qj == 0) && (ent[i].Qk == 0);
        if (ent[i].e_state == S_ADDR_GENERATED) begin
            for (int j = 0; j < BUF_SIZE; j++)
                if (ent[j].Unit == STORE && ent[j].tag != 0 && ent[j].tag > ent[i].tag)
                    return 1'b0;
            return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic bit tag_used(int t);
        for (int i = 0; i < BUF_SIZE; i++)
            if (ent[i].tag == t) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_clear();
        for (int k = 0; k < IW; k++) begin
            m_valid[k] = 1'b0;
            m_idx[k]   = 0;
            m_tag[k]   = 0;
        end
    endtask

    task automatic set_ent(int i, int t, e_state_t st, int qj, unit_t u);
        ent[i].tag     = TAG_W'(t);
        ent[i].e_state = st;
        ent[i].Qj      = TAG_W'(qj);
        ent[i].Qk      = '0;
        ent[i].Unit    = u;
    endtask

    task automatic clear_buf();
        for (int i = 0; i < BUF_SIZE; i++) set_ent(i, 0, S_NOT_EXECUTED, 0, ALU);
    endtask

    // One clock: compare at negedge, predict the next channel state, advance,
    // then let the buffer retire fired entries just after the edge.
    task automatic cycle();
        int   order[$];
        logic [BUF_SIZE-1:0] fexp;
        int   p;
        bit   nv [IW];
        int   ni [IW];
        int   nt [IW];
        @(negedge clk);
        for (int k = 0; k < IW; k++) begin
            check_eq($sformatf("ch%0d_valid", k), 32'(issue_valid[k]), 32'(m_valid[k]));
            if (m_valid[k]) begin
                check_eq($sformatf("ch%0d_idx", k), 32'(issue_idx[k]), m_idx[k]);
                check_eq($sformatf("ch%0d_tag", k), 32'(issue_tag[k]), m_tag[k]);
            end
        end
        fexp = '0;
        for (int k = 0; k < IW; k++)
            if (m_valid[k] && fu_ready[k]) fexp[m_idx[k]] = 1'b1;
        check_eq("issue_fire", 32'(issue_fire), 32'(fexp));
        seen_fire = issue_fire;
        // oldest-first list of eligible entries, bucketed by tag value
        for (int t = (1 << TAG_W) - 1; t >= 1; t--)
            for (int i = 0; i < BUF_SIZE; i++)
                if (ent[i].tag == t && eligible(i)) order.push_back(i);
        p = 0;
        for (int k = 0; k < IW; k++) begin
            nv[k] = m_valid[k];
            ni[k] = m_idx[k];
            nt[k] = m_tag[k];
            if (flush) begin
                nv[k] = 1'b0;
            end else if (!m_valid[k] || fu_ready[k]) begin
                if (p < order.size()) begin
                    nv[k] = 1'b1;
                    ni[k] = order[p];
                    nt[k] = int'(ent[order[p]].tag);
                    p++;
                end else begin
                    nv[k] = 1'b0;
                end
            end
        end
        @(posedge clk);
        for (int k = 0; k < IW; k++) begin
            m_valid[k] = nv[k];
            m_idx[k]   = ni[k];
            m_tag[k]   = nt[k];
        end
        #1;
        for (int i = 0; i < BUF_SIZE; i++)
            if (fexp[i]) ent[i].e_state = S_EXECUTING;
    endtask

    task automatic drain();
        fu_ready = '1;
        flush    = 1'b0;
        cycle();
        cycle();
    endtask

    // Random buffer traffic that never touches entries held by a channel
    task automatic rand_inputs();
        int r;
        int t;
        for (int i = 0; i < BUF_SIZE; i++) begin
            if (held(i)) continue;
            r = int'($urandom_range(0, 15));
            if (ent[i].tag == 0) begin
                if (r < 5) begin
                    do t = int'($urandom_range(1, (1 << TAG_W) - 1)); while (tag_used(t));
                    set_ent(i, t,
                            ($urandom_range(0, 1) == 0) ? S_NOT_EXECUTED : S_ADDR_GENERATED,
                            ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 15)),
                            unit_t'($urandom_range(0, 3)));
                    ent[i].Qk = ($urandom_range(0, 2) == 0) ? TAG_W'($urandom_range(1, 15)) : '0;
                end
            end else if (ent[i].e_state == S_EXECUTING) begin
                if (r < 6) ent[i].tag = '0;
            end else if (r < 3) begin
                ent[i].Qj = '0;
            end else if (r < 5) begin
                ent[i].Qk = '0;
            end else if (r == 5) begin
                ent[i].tag = '0;
            end
        end
        fu_ready = IW'($urandom);
        flush    = ($urandom_range(0, 15) == 0);
    endtask

    initial begin
        rst      = 1'b1;
        flush    = 1'b0;
        fu_ready = '1;
        model_clear();
        clear_buf();
        set_ent(0, 5, S_NOT_EXECUTED, 0, ALU);
        set_ent(1, 9, S_NOT_EXECUTED, 0, ALU);
        set_ent(2, 3, S_NOT_EXECUTED, 0, ALU);

        // reset holds outputs quiet even with ready entries and ready units
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_valid", 32'(issue_valid), 32'd0);
        check_eq("rst_fire", 32'(issue_fire), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // tags {5,9,3}: oldest two first, then the remaining one
        cycle();
        check_eq("t2_valid_a", 32'(issue_valid), 32'b11);
        check_eq("t2_ch0_tag9", 32'(issue_tag[0]), 32'd9);
        check_eq("t2_ch1_tag5", 32'(issue_tag[1]), 32'd5);
        cycle();
        check_eq("t2_valid_b", 32'(issue_valid), 32'b01);
        check_eq("t2_ch0_tag3", 32'(issue_tag[0]), 32'd3);

        // ch0 held on tag9 while ch1 keeps flowing
        drain();
        clear_buf();
        set_ent(1, 9, S_NOT_EXECUTED, 0, ALU);
        set_ent(2, 4, S_NOT_EXECUTED, 0, ALU);
        fu_ready = 2'b10;
        cycle();
        for (int c = 0; c < 3; c++) begin
            check_eq("t3_hold_tag", 32'(issue_tag[0]), 32'd9);
            check_eq("t3_hold_idx", 32'(issue_idx[0]), 32'd1);
            cycle();
            check_eq("t3_no_fire", 32'(seen_fire[1]), 32'd0);
        end
        fu_ready = 2'b11;
        cycle();
        check_eq("t3_fire", 32'(seen_fire[1]), 32'd1);

        // load blocked by an older store until the store leaves
        drain();
        clear_buf();
        set_ent(0, 4, S_ADDR_GENERATED, 0, LOAD);
        set_ent(3, 6, S_NOT_EXECUTED, 3, STORE);
        fu_ready = 2'b00;
        cycle();
        cycle();
        check_eq("t4_blocked", 32'(issue_valid), 32'd0);
        ent[3].tag = '0;
        cycle();
        check_eq("t4_load_valid", 32'(issue_valid[0]), 32'd1);
        check_eq("t4_load_tag", 32'(issue_tag[0]), 32'd4);

        // operand dependency holds back the older entry
        drain();
        clear_buf();
        set_ent(4, 7, S_NOT_EXECUTED, 2, ALU);
        set_ent(5, 2, S_NOT_EXECUTED, 0, ALU);
        fu_ready = 2'b11;
        cycle();
        check_eq("t5_only_tag2", 32'(issue_valid), 32'b01);
        check_eq("t5_tag2", 32'(issue_tag[0]), 32'd2);
        ent[4].Qj = '0;
        cycle();
        check_eq("t5_tag7", 32'(issue_tag[0]), 32'd7);

        // flush with both channels valid and ch1 firing
        drain();
        clear_buf();
        set_ent(0, 8, S_NOT_EXECUTED, 0, ALU);
        set_ent(1, 6, S_NOT_EXECUTED, 0, ALU);
        set_ent(2, 3, S_NOT_EXECUTED, 0, ALU);
        fu_ready = 2'b00;
        cycle();
        check_eq("t6_both_valid", 32'(issue_valid), 32'b11);
        fu_ready = 2'b10;
        flush    = 1'b1;
        cycle();
        check_eq("t6_fire_ch1", 32'(seen_fire), 32'b0000_0010);
        check_eq("t6_flushed", 32'(issue_valid), 32'd0);
        flush = 1'b0;

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            rand_inputs();
            cycle();
        end

        // reset asserted mid-handshake
        drain();
        clear_buf();
        set_ent(0, 8, S_NOT_EXECUTED, 0, ALU);
        set_ent(1, 6, S_NOT_EXECUTED, 0, ALU);
        fu_ready = 2'b00;
        cycle();
        check_eq("t7_pre_valid", 32'(issue_valid), 32'b11);
        fu_ready = 2'b11;
        #2 rst = 1'b1;
        #1;
        check_eq("t7_rst_valid", 32'(issue_valid), 32'd0);
        check_eq("t7_rst_fire", 32'(issue_fire), 32'd0);
        check_eq("t7_rst_idx", 32'(issue_idx), 32'd0);
        check_eq("t7_rst_tag", 32'(issue_tag), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        model_clear();
        cycle();
        check_eq("t7_post_valid", 32'(issue_valid), 32'b11);
        check_eq("t7_post_tag", 32'(issue_tag[0]), 32'd8);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
